// File: rtl/bank_wb_buffer_if.sv
// Bundle of the SRAM half-line input, AXI3 W output and status signals of the
// bank writeback buffer; slave is the buffer side, master is the driver side.
interface bank_wb_buffer_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 8,
  parameter int DEPTH      = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                    sc_wbb_valid_i;
  logic                    sc_wbb_ready_o;
  logic [DATA_WIDTH/2-1:0] sc_wbb_data_i;
  logic                    sc_wbb_offset_i;
  logic [5:0]              sc_wbb_set_way_i;
  logic                    wbb_axi3_wvalid_o;
  logic                    wbb_axi3_wready_i;
  logic [ID_WIDTH-1:0]     wbb_axi3_wid_o;
  logic [DATA_WIDTH-1:0]   wbb_axi3_wdata_o;
  logic [DATA_WIDTH/8-1:0] wbb_axi3_wstrb_o;
  logic                    wbb_axi3_wlast_o;
  logic [CW-1:0]           wbb_count_o;
  logic                    wbb_err_o;

  modport slave (
    input  sc_wbb_valid_i, sc_wbb_data_i, sc_wbb_offset_i, sc_wbb_set_way_i,
    input  wbb_axi3_wready_i,
    output sc_wbb_ready_o, wbb_axi3_wvalid_o, wbb_axi3_wid_o, wbb_axi3_wdata_o,
    output wbb_axi3_wstrb_o, wbb_axi3_wlast_o, wbb_count_o, wbb_err_o
  );

  modport master (
    output sc_wbb_valid_i, sc_wbb_data_i, sc_wbb_offset_i, sc_wbb_set_way_i,
    output wbb_axi3_wready_i,
    input  sc_wbb_ready_o, wbb_axi3_wvalid_o, wbb_axi3_wid_o, wbb_axi3_wdata_o,
    input  wbb_axi3_wstrb_o, wbb_axi3_wlast_o, wbb_count_o, wbb_err_o
  );
endinterface

// File: rtl/bank_wb_buffer.sv
// Bank writeback buffer: pairs two 128-bit victim halves into one 256-bit line,
// queues lines in a small FIFO and emits each as a single-beat AXI3 W transfer.
module bank_wb_buffer #(
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 8,
  parameter int DEPTH      = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  bank_wb_buffer_if.slave  bus
);
  localparam int HALF_W = DATA_WIDTH / 2;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(DEPTH) + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HALF = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [HALF_W-1:0]     r_hold_data;
  logic [5:0]            r_hold_sw;
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [5:0]            r_mem_sw   [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_err;

  logic w_full;
  logic w_empty;
  logic w_ready;
  logic w_xfer;
  logic w_pop;
  logic w_push;
  logic w_hold_load;
  logic w_err;

  // Ready depends only on registered state, never on wready.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == {CW{1'b0}});
  assign w_ready = (r_state == ST_IDLE) | ~w_full;
  assign w_xfer  = bus.sc_wbb_valid_i & w_ready;
  assign w_pop   = ~w_empty & bus.wbb_axi3_wready_i;

  always_comb begin
    w_next_state = r_state;
    w_hold_load  = 1'b0;
    w_push       = 1'b0;
    w_err        = 1'b0;
    if (w_xfer) begin
      case (r_state)
        ST_IDLE: begin
          if (!bus.sc_wbb_offset_i) begin
            w_hold_load  = 1'b1;
            w_next_state = ST_HALF;
          end else begin
            w_err        = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
        ST_HALF: begin
          if (!bus.sc_wbb_offset_i) begin
            w_hold_load  = 1'b1;
            w_err        = 1'b1;
            w_next_state = ST_HALF;
          end else if (bus.sc_wbb_set_way_i == r_hold_sw) begin
            w_push       = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_err        = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_err   <= w_err;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold_data <= {HALF_W{1'b0}};
      r_hold_sw   <= 6'h00;
    end else if (w_hold_load) begin
      r_hold_data <= bus.sc_wbb_data_i;
      r_hold_sw   <= bus.sc_wbb_set_way_i;
    end else begin
      r_hold_data <= r_hold_data;
      r_hold_sw   <= r_hold_sw;
    end
  end

  // Storage is cleared on reset so the idle W bus reads back as zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= {DATA_WIDTH{1'b0}};
        r_mem_sw[i]   <= 6'h00;
      end
    end else if (w_push) begin
      r_mem_data[r_wptr] <= {bus.sc_wbb_data_i, r_hold_data};
      r_mem_sw[r_wptr]   <= r_hold_sw;
    end else begin
      r_mem_data[r_wptr] <= r_mem_data[r_wptr];
      r_mem_sw[r_wptr]   <= r_mem_sw[r_wptr];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end else begin
        r_rptr <= r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.sc_wbb_ready_o    = w_ready;
  assign bus.wbb_axi3_wvalid_o = ~w_empty;
  assign bus.wbb_axi3_wdata_o  = r_mem_data[r_rptr];
  assign bus.wbb_axi3_wid_o    = {{(ID_WIDTH-6){1'b0}}, r_mem_sw[r_rptr]};
  assign bus.wbb_axi3_wstrb_o  = {(DATA_WIDTH/8){1'b1}};
  assign bus.wbb_axi3_wlast_o  = 1'b1;
  assign bus.wbb_count_o       = r_count;
  assign bus.wbb_err_o         = r_err;
endmodule

// File: tb/tb_bank_wb_buffer.sv
// Directed self-checking bench for bank_wb_buffer with hand-computed lines.
module tb_bank_wb_buffer;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bank_wb_buffer_if #(.DATA_WIDTH(256), .ID_WIDTH(8), .DEPTH(2)) bus();

  bank_wb_buffer #(.DATA_WIDTH(256), .ID_WIDTH(8), .DEPTH(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the transfer edge.
  task automatic drive_half(input logic off, input logic [127:0] d, input logic [5:0] sw);
    int n;
    bus.sc_wbb_valid_i   = 1'b1;
    bus.sc_wbb_offset_i  = off;
    bus.sc_wbb_data_i    = d;
    bus.sc_wbb_set_way_i = sw;
    n = 0;
    while (!bus.sc_wbb_ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("ready_timeout", 256'd0, 256'd1);
    @(posedge clk); #1;
    bus.sc_wbb_valid_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [127:0] lo, hi;
  logic [5:0]   sw;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.sc_wbb_valid_i = 1'b0;
    bus.sc_wbb_offset_i = 1'b0;
    bus.sc_wbb_data_i = 128'd0;
    bus.sc_wbb_set_way_i = 6'h00;
    bus.wbb_axi3_wready_i = 1'b0;
    tick(); tick();
    chk("rst_wvalid", 256'(bus.wbb_axi3_wvalid_o), 256'd0);
    chk("rst_count",  256'(bus.wbb_count_o), 256'd0);
    chk("rst_ready",  256'(bus.sc_wbb_ready_o), 256'd1);
    chk("rst_err",    256'(bus.wbb_err_o), 256'd0);
    chk("rst_wid",    256'(bus.wbb_axi3_wid_o), 256'd0);
    chk("rst_wdata",  bus.wbb_axi3_wdata_o, 256'd0);
    rst = 1'b0;
    tick();

    // Single line
    drive_half(1'b0, {32{4'hA}}, 6'h05);
    chk("t1_lo_wvalid", 256'(bus.wbb_axi3_wvalid_o), 256'd0);
    drive_half(1'b1, {32{4'hB}}, 6'h05);
    chk("t1_wvalid", 256'(bus.wbb_axi3_wvalid_o), 256'd1);
    chk("t1_wdata",  bus.wbb_axi3_wdata_o, {{32{4'hB}}, {32{4'hA}}});
    chk("t1_wid",    256'(bus.wbb_axi3_wid_o), 256'h05);
    chk("t1_wstrb",  256'(bus.wbb_axi3_wstrb_o), 256'hFFFFFFFF);
    chk("t1_wlast",  256'(bus.wbb_axi3_wlast_o), 256'd1);
    chk("t1_count1", 256'(bus.wbb_count_o), 256'd1);
    bus.wbb_axi3_wready_i = 1'b1;
    tick();
    bus.wbb_axi3_wready_i = 1'b0;
    chk("t1_count0", 256'(bus.wbb_count_o), 256'd0);
    chk("t1_wvalid0", 256'(bus.wbb_axi3_wvalid_o), 256'd0);

    // Backpressure and full
    drive_half(1'b0, {32{4'h1}}, 6'h11);
    drive_half(1'b1, {32{4'h2}}, 6'h11);
    drive_half(1'b0, {32{4'h3}}, 6'h12);
    drive_half(1'b1, {32{4'h4}}, 6'h12);
    chk("t2_count2", 256'(bus.wbb_count_o), 256'd2);
    chk("t2_ready_idle_full", 256'(bus.sc_wbb_ready_o), 256'd1);
    drive_half(1'b0, {32{4'h5}}, 6'h13);
    chk("t2_ready_half_full", 256'(bus.sc_wbb_ready_o), 256'd0);
    bus.sc_wbb_valid_i = 1'b1;
    bus.sc_wbb_offset_i = 1'b1;
    bus.sc_wbb_data_i = {32{4'h6}};
    bus.sc_wbb_set_way_i = 6'h13;
    tick();
    chk("t2_stall_ready", 256'(bus.sc_wbb_ready_o), 256'd0);
    chk("t2_stall_count", 256'(bus.wbb_count_o), 256'd2);
    chk("t2_head1", bus.wbb_axi3_wdata_o, {{32{4'h2}}, {32{4'h1}}});
    bus.wbb_axi3_wready_i = 1'b1;
    tick();
    chk("t2_pop1_count", 256'(bus.wbb_count_o), 256'd1);
    chk("t2_head2", bus.wbb_axi3_wdata_o, {{32{4'h4}}, {32{4'h3}}});
    chk("t2_head2_wid", 256'(bus.wbb_axi3_wid_o), 256'h12);
    tick();
    bus.sc_wbb_valid_i = 1'b0;
    chk("t2_pushpop_count", 256'(bus.wbb_count_o), 256'd1);
    chk("t2_head3", bus.wbb_axi3_wdata_o, {{32{4'h6}}, {32{4'h5}}});
    chk("t2_head3_wid", 256'(bus.wbb_axi3_wid_o), 256'h13);
    tick();
    chk("t2_drained", 256'(bus.wbb_count_o), 256'd0);

    // Streaming with wready=1, pointers wrap several times
    for (int i = 0; i < 6; i++) begin
      lo = {4{32'h1000_0000 + 32'(i)}};
      hi = {4{32'h2000_0000 + 32'(i)}};
      sw = 6'(20 + i);
      drive_half(1'b0, lo, sw);
      chk("t3_lo_count", 256'(bus.wbb_count_o), 256'd0);
      drive_half(1'b1, hi, sw);
      chk("t3_count", 256'(bus.wbb_count_o), 256'd1);
      chk("t3_wdata", bus.wbb_axi3_wdata_o, {hi, lo});
      chk("t3_wid",   256'(bus.wbb_axi3_wid_o), 256'(sw));
    end
    tick();
    chk("t3_drained", 256'(bus.wbb_count_o), 256'd0);
    bus.wbb_axi3_wready_i = 1'b0;

    // Protocol errors
    drive_half(1'b1, {32{4'h7}}, 6'h07);
    chk("t4a_err", 256'(bus.wbb_err_o), 256'd1);
    chk("t4a_count", 256'(bus.wbb_count_o), 256'd0);
    tick();
    chk("t4a_err_pulse", 256'(bus.wbb_err_o), 256'd0);
    drive_half(1'b0, {32{4'hC}}, 6'h01);
    chk("t4b_err0", 256'(bus.wbb_err_o), 256'd0);
    drive_half(1'b0, {32{4'hD}}, 6'h02);
    chk("t4b_err1", 256'(bus.wbb_err_o), 256'd1);
    drive_half(1'b1, {32{4'hE}}, 6'h02);
    chk("t4b_err2", 256'(bus.wbb_err_o), 256'd0);
    chk("t4b_wdata", bus.wbb_axi3_wdata_o, {{32{4'hE}}, {32{4'hD}}});
    chk("t4b_wid", 256'(bus.wbb_axi3_wid_o), 256'h02);
    bus.wbb_axi3_wready_i = 1'b1;
    tick();
    bus.wbb_axi3_wready_i = 1'b0;
    drive_half(1'b0, {32{4'h8}}, 6'h03);
    drive_half(1'b1, {32{4'h9}}, 6'h04);
    chk("t4c_err", 256'(bus.wbb_err_o), 256'd1);
    chk("t4c_count", 256'(bus.wbb_count_o), 256'd0);
    chk("t4c_wvalid", 256'(bus.wbb_axi3_wvalid_o), 256'd0);
    drive_half(1'b0, {32{4'hF}}, 6'h09);
    chk("t4c_idle_err", 256'(bus.wbb_err_o), 256'd0);
    drive_half(1'b1, {32{4'h0}}, 6'h09);
    chk("t4c_wdata", bus.wbb_axi3_wdata_o, {{32{4'h0}}, {32{4'hF}}});
    bus.wbb_axi3_wready_i = 1'b1;
    tick();
    bus.wbb_axi3_wready_i = 1'b0;

    // Reset with two lines queued and a half held
    drive_half(1'b0, {32{4'h1}}, 6'h21);
    drive_half(1'b1, {32{4'h2}}, 6'h21);
    drive_half(1'b0, {32{4'h3}}, 6'h22);
    drive_half(1'b1, {32{4'h4}}, 6'h22);
    drive_half(1'b0, {32{4'h5}}, 6'h23);
    chk("t5_pre_count", 256'(bus.wbb_count_o), 256'd2);
    rst = 1'b1;
    #1;
    chk("t5_wvalid", 256'(bus.wbb_axi3_wvalid_o), 256'd0);
    chk("t5_count", 256'(bus.wbb_count_o), 256'd0);
    chk("t5_ready", 256'(bus.sc_wbb_ready_o), 256'd1);
    chk("t5_wdata", bus.wbb_axi3_wdata_o, 256'd0);
    tick();
    rst = 1'b0;
    drive_half(1'b0, {32{4'h6}}, 6'h15);
    chk("t5_fresh_err", 256'(bus.wbb_err_o), 256'd0);
    drive_half(1'b1, {32{4'h7}}, 6'h15);
    chk("t5_line_count", 256'(bus.wbb_count_o), 256'd1);
    chk("t5_line", bus.wbb_axi3_wdata_o, {{32{4'h7}}, {32{4'h6}}});
    bus.wbb_axi3_wready_i = 1'b1;
    tick();
    bus.wbb_axi3_wready_i = 1'b0;
    chk("t5_alone", 256'(bus.wbb_axi3_wvalid_o), 256'd0);

    // Head stability under backpressure while a new line is pushed
    drive_half(1'b0, {32{4'hA}}, 6'h31);
    drive_half(1'b1, {32{4'hB}}, 6'h31);
    drive_half(1'b0, {32{4'hC}}, 6'h32);
    chk("t6_hold_lo", bus.wbb_axi3_wdata_o, {{32{4'hB}}, {32{4'hA}}});
    drive_half(1'b1, {32{4'hD}}, 6'h32);
    chk("t6_hold_hi", bus.wbb_axi3_wdata_o, {{32{4'hB}}, {32{4'hA}}});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_hold_data", bus.wbb_axi3_wdata_o, {{32{4'hB}}, {32{4'hA}}});
      chk("t6_hold_wid", 256'(bus.wbb_axi3_wid_o), 256'h31);
    end
    bus.wbb_axi3_wready_i = 1'b1;
    tick();
    chk("t6_next", bus.wbb_axi3_wdata_o, {{32{4'hD}}, {32{4'hC}}});
    chk("t6_next_wid", 256'(bus.wbb_axi3_wid_o), 256'h32);
    tick();
    bus.wbb_axi3_wready_i = 1'b0;
    chk("t6_drained", 256'(bus.wbb_count_o), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bank_wb_buffer.md
# bank_wb_buffer

The bank writeback buffer sits between the bank SRAM readout (sc) and the bank BIU's AXI3 W channel. It accepts a victim cache line as two 128-bit halves, assembles them into one 256-bit line tagged with its set/way, and queues assembled lines in a small FIFO. It then presents each line as a single-beat AXI3 write-data transfer (len 0, full strobe, last=1).

## Interface
Parameters:
- DATA_WIDTH, 256, assembled line / W beat width; fixed at 2×128
- ID_WIDTH, 8, AXI ID width; wid = {zero pad, set_way[5:0]}
- DEPTH, 2, FIFO entries; power of two, ≥2

Ports:
- clk_i  input  1  clock; all state on rising edge
- rst_i  input  1  reset; asynchronous, active-high
- sc_wbb_valid_i  input  1  SRAM half-line valid
- sc_wbb_ready_o  output  1  buffer can accept a half-line
- sc_wbb_data_i  input  128  half-line data
- sc_wbb_offset_i  input  1  0 = low half [127:0], 1 = high half [255:128]
- sc_wbb_set_way_i  input  6  set/way of the line being written back
- wbb_axi3_wvalid_o  output  1  W beat valid
- wbb_axi3_wready_i  input  1  W beat accepted
- wbb_axi3_wid_o  output  ID_WIDTH  {zeros, set_way}
- wbb_axi3_wdata_o  output  DATA_WIDTH  assembled line
- wbb_axi3_wstrb_o  output  DATA_WIDTH/8  all ones
- wbb_axi3_wlast_o  output  1  constant 1
- wbb_count_o  output  clog2(DEPTH)+1  FIFO occupancy
- wbb_err_o  output  1  one-cycle pulse on protocol error

## Operation
- Half-line handshake: a beat transfers when sc_wbb_valid_i & sc_wbb_ready_o.
- Assembler FSM has two states:
  - IDLE: expects a low half. A low half is stored in the hold register with its set_way → HALF.
  - HALF: the low half is held. A high half with matching set_way pushes {set_way, high, low} into the FIFO → IDLE.
- Error cases (each raises wbb_err_o for the cycle after the transfer):
  - IDLE, high half arrives: the beat is accepted and discarded; the FSM stays in IDLE.
  - HALF, low half arrives: the new beat replaces the hold register; the FSM stays in HALF.
  - HALF, high half with mismatched set_way: both halves are discarded → IDLE.
- sc_wbb_ready_o = (state==IDLE) | ~full. It is driven from registered state only; there is no combinational path from wbb_axi3_wready_i.
- FIFO:
  - Read and write pointers are clog2(DEPTH) bits and wrap naturally.
  - full = (count==DEPTH); empty = (count==0).
  - Push and pop in the same cycle leave count unchanged.
- W output:
  - wvalid = ~empty.
  - wdata and wid come from the FIFO head.
  - While wvalid=1 and wready=0, the head is held stable (AXI rule).
- wstrb and wlast are constants: all ones and 1.

## Timing
- Reset values, asynchronous on rst_i:
  - state IDLE, pointers 0, count 0.
  - wvalid=0, wid=0, wdata=0 (storage is cleared), err=0, ready=1.
- Reset mid-operation discards the hold register and all queued lines; the cycle after reset release behaves as a fresh IDLE.
- Latency: a high half accepted in cycle N → wvalid=1 with that line in cycle N+1 (FIFO previously empty).
- Pop: in a cycle with wvalid & wready, the next entry (if any) is presented in cycle N+1; otherwise wvalid=0 in N+1.
- Throughput:
  - One half-line per cycle in.
  - One line per cycle out.
  - Sustained rate is one line per 2 cycles, limited by the input.
- Full boundary:
  - With count==DEPTH in HALF, ready=0 and the high half is stalled.
  - Low halves in IDLE are still accepted into the hold register.
- Simultaneous push into a full FIFO with a pop cannot occur, because ready uses registered full.
- Simultaneous push and pop at count 1..DEPTH-1 leave count unchanged, and pointer wrap is preserved.
- wbb_count_o is registered and reflects pushes and pops of the previous cycle.

## Test plan
- Single line:
  - Stimulus: low=128'hA…A, set_way 6'h05; then high=128'hB…B, set_way 6'h05.
  - Response: wvalid the next cycle; wdata={B…B, A…A}, wid=8'h05, wstrb=32'hFFFFFFFF, wlast=1; count 1→0 after a wready handshake.
- Backpressure and full:
  - Stimulus: hold wready=0; send three lines (DEPTH=2).
  - Response: count reaches 2; the third low half is accepted; the third high half sees ready=0. Release wready: the lines are popped in order and the third line enters the FIFO.
- Wrap-around and simultaneous push/pop:
  - Stimulus: stream 6 lines with wready=1.
  - Response: data and wid match in order; count never exceeds 1; pointers wrap without loss.
- Protocol errors:
  - High half in IDLE → err pulse, no FIFO entry.
  - Low half 6'h01 then low half 6'h02 then high half 6'h02 → err pulse once; the output line carries the second low half.
  - Low half 6'h03 then high half 6'h04 → err pulse, nothing pushed, FSM returns to IDLE.
- Reset mid-operation:
  - Stimulus: assert rst_i with FSM in HALF and 2 lines queued.
  - Response: immediately wvalid=0, count=0, ready=1; the next clean line after release is output alone.
- Head stability:
  - Stimulus: with wvalid=1, toggle wready=0 for 5 cycles while sc pushes a new line.
  - Response: wdata and wid are unchanged until the handshake completes.
